snake_board_render: RTL and testbench

//  Downstream pixel stage of the 640x480 VGA timing generator. Consumes raw hc/vc and hsync/vsync.

---
 rtl/snake_board_render.sv | 191 +++++++++++++++++++
 tb/tb_snake_board_render.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_board_render.sv
// snake_board_render: 40x30 cell board RAM rendered onto 640x480 VGA timing, 3-cycle pixel pipeline.
// Define SNAKE_GRID_LINES_EN to draw grey cell borders over empty cells.
module snake_board_render #(
  parameter int HBP       = 144,
  parameter int HFP       = 784,
  parameter int VBP       = 31,
  parameter int VFP       = 511,
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int CELL_LOG2 = 4
) (
  input  logic       dclk,
  input  logic       rst_n,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [1:0] wr_data,
  input  logic       clr,
  output logic       busy,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam logic [10:0] LAST_ADDR = 11'(CELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_reg;
  logic [10:0] sweep_reg;

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      sweep_reg <= '0;
      busy      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr) begin
            state_reg <= CLEAR;
            sweep_reg <= '0;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr) begin
            sweep_reg <= '0;
          end else if (sweep_reg == LAST_ADDR) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            sweep_reg <= sweep_reg + 11'd1;
          end
        end
      endcase
    end
  end

  // Board write port: the clear sweep owns it while running, game writes are dropped.
  logic [10:0] wr_row;
  logic [10:0] wr_addr;
  logic        wr_ok;
  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [1:0]  ram_wdata;

  assign wr_row  = {6'b0, wr_y};
  assign wr_addr = (wr_row << 5) + (wr_row << 3) + {5'b0, wr_x};
  assign wr_ok   = wr_en && (wr_x < 6'(GRID_W)) && (wr_y < 5'(GRID_H));

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (state_reg == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_reg;
      ram_wdata = 2'd0;
    end else if (wr_ok) begin
      ram_we = 1'b1;
    end
  end

  // Stage 1: cell address and visibility from the raw counters.
  logic [9:0]  hx;
  logic [9:0]  vy;
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [10:0] rd_addr;
  logic        in_view;

  assign hx      = hc - 10'(HBP);
  assign vy      = vc - 10'(VBP);
  assign cx      = hx >> CELL_LOG2;
  assign cy      = vy >> CELL_LOG2;
  assign rd_addr = ({1'b0, cy} << 5) + ({1'b0, cy} << 3) + {1'b0, cx};
  assign in_view = (hc >= 10'(HBP)) && (hc < 10'(HFP)) &&
                   (vc >= 10'(VBP)) && (vc < 10'(VFP));

  logic        act1_reg;
  logic        act2_reg;
  logic [10:0] addr1_reg;
  logic        hs1_reg;
  logic        hs2_reg;
  logic        vs1_reg;
  logic        vs2_reg;
  logic [1:0]  code2_reg;
  logic [7:0]  pixel;

  // Read-first block RAM: the registered read sees the pre-write contents.
  logic [1:0] ram [CELLS];

  always_ff @(posedge dclk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
    code2_reg <= ram[addr1_reg];
  end

`ifdef SNAKE_GRID_LINES_EN
  logic [CELL_LOG2-1:0] ox1_reg;
  logic [CELL_LOG2-1:0] oy1_reg;
  logic [CELL_LOG2-1:0] ox2_reg;
  logic [CELL_LOG2-1:0] oy2_reg;

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      ox1_reg <= '0;
      oy1_reg <= '0;
      ox2_reg <= '0;
      oy2_reg <= '0;
    end else begin
      ox1_reg <= hx[CELL_LOG2-1:0];
      oy1_reg <= vy[CELL_LOG2-1:0];
      ox2_reg <= ox1_reg;
      oy2_reg <= oy1_reg;
    end
  end
`else
  logic [2*CELL_LOG2-1:0] unused_offsets;
  assign unused_offsets = {hx[CELL_LOG2-1:0], vy[CELL_LOG2-1:0]};
`endif

  always_comb begin
    pixel = 8'h00;
    case (code2_reg)
      2'd0:    pixel = 8'h00;
      2'd1:    pixel = 8'h1C;
      2'd2:    pixel = 8'hFC;
      default: pixel = 8'hE0;
    endcase
`ifdef SNAKE_GRID_LINES_EN
    if ((code2_reg == 2'd0) && ((ox2_reg == '0) || (oy2_reg == '0))) begin
      pixel = 8'h49;
    end
`endif
  end

  // Syncs ride the same three stages as the colour and are never blanked.
  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      act1_reg  <= 1'b0;
      act2_reg  <= 1'b0;
      addr1_reg <= '0;
      hs1_reg   <= 1'b1;
      hs2_reg   <= 1'b1;
      vs1_reg   <= 1'b1;
      vs2_reg   <= 1'b1;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      rgb       <= 8'h00;
    end else begin
      act1_reg  <= in_view;
      addr1_reg <= in_view ? rd_addr : 11'd0;
      hs1_reg   <= hsync_in;
      vs1_reg   <= vsync_in;
      act2_reg  <= act1_reg;
      hs2_reg   <= hs1_reg;
      vs2_reg   <= vs1_reg;
      hsync     <= hs2_reg;
      vsync     <= vs2_reg;
      rgb       <= act2_reg ? pixel : 8'h00;
    end
  end

endmodule

// File: tb/tb_snake_board_render.sv
// Self-checking bench for snake_board_render: directed tables, multi-cycle sequences, random traffic vs model.
`timescale 1ns/1ps
module tb_snake_board_render;
`ifdef SNAKE_GRID_LINES_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif
  localparam int G = GRID ? 'h49 : 'h00;

  logic       dclk = 1'b0;
  logic       rst_n;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hsync_in;
  logic       vsync_in;
  logic       wr_en;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [1:0] wr_data;
  logic       clr;
  logic       busy;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;

  snake_board_render dut (
    .dclk(dclk), .rst_n(rst_n), .hc(hc), .vc(vc),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clr(clr), .busy(busy), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #20 dclk = ~dclk;

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: board as a flat array of codes (-1 = never written), clear as a cell counter.
  int       board[1200];
  bit       m_clear;
  int       m_pos;
  bit       p_act;
  int       p_cell, p_ox, p_oy;
  bit       q_act;
  int       q_code, q_ox, q_oy;
  int       exp_rgb;
  bit [2:0] hs_h, vs_h;

  function automatic int colour(bit act, int code, int ox, int oy);
    if (!act) return 0;
    if (code < 0) return -1;
    if (code == 0) return (GRID && (ox == 0 || oy == 0)) ? 'h49 : 'h00;
    case (code)
      1: return 'h1C;
      2: return 'hFC;
      default: return 'hE0;
    endcase
  endfunction

  function automatic void model_edge();
    int xr, yr;
    if (!rst_n) begin
      exp_rgb = 0; p_act = 0; q_act = 0; q_code = 0;
      hs_h = 3'b111; vs_h = 3'b111; m_clear = 1; m_pos = 0;
      return;
    end
    exp_rgb = colour(q_act, q_code, q_ox, q_oy);
    q_act  = p_act;
    q_code = p_act ? board[p_cell] : 0;
    q_ox   = p_ox;
    q_oy   = p_oy;
    p_act  = (hc >= 144) && (hc < 784) && (vc >= 31) && (vc < 511);
    xr = int'(hc) - 144;
    yr = int'(vc) - 31;
    p_cell = p_act ? (yr / 16) * 40 + xr / 16 : 0;
    p_ox   = p_act ? xr % 16 : 0;
    p_oy   = p_act ? yr % 16 : 0;
    hs_h = {hs_h[1:0], hsync_in};
    vs_h = {vs_h[1:0], vsync_in};
    if (m_clear) begin
      board[m_pos] = 0;
      if (clr) m_pos = 0;
      else if (m_pos == 1199) m_clear = 0;
      else m_pos++;
    end else begin
      if (wr_en && wr_x < 40 && wr_y < 30) board[int'(wr_y) * 40 + int'(wr_x)] = int'(wr_data);
      if (clr) begin m_clear = 1; m_pos = 0; end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge dclk);
    #1;
    check("busy", int'(busy), int'(m_clear));
    check("hsync", int'(hsync), int'(hs_h[2]));
    check("vsync", int'(vsync), int'(vs_h[2]));
    if (exp_rgb >= 0) check("rgb", int'(rgb), exp_rgb);
  endtask

  task automatic busy_run(output int n);
    n = 0;
    while (busy && n < 1300) begin
      n++;
      tick();
    end
  endtask

  task automatic write_cell(input int x, input int y, input int d);
    wr_en = 1'b1; wr_x = 6'(x); wr_y = 5'(y); wr_data = 2'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic probe(input int x, input int y, output int got);
    hc = 10'(x); vc = 10'(y);
    tick();
    hc = '0; vc = '0;
    tick();
    tick();
    got = int'(rgb);
  endtask

  task automatic scan_board(input string name);
    int nz = 0;
    for (int c = 0; c < 1200; c++) begin
      hc = 10'(144 + (c % 40) * 16 + 5);
      vc = 10'(31 + (c / 40) * 16 + 5);
      tick();
      if (rgb != 8'h00) nz++;
    end
    hc = '0; vc = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (rgb != 8'h00) nz++;
    end
    check(name, nz, 0);
  endtask

  typedef struct {
    int hc;
    int vc;
    int rgb;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    int   n, got, first_low, low_cnt, bad;

    tbl.push_back('{144, 31, 'hFC});
    tbl.push_back('{159, 31, 'hFC});
    tbl.push_back('{160, 31, G});
    tbl.push_back('{161, 32, 'h00});
    tbl.push_back('{143, 31, 'h00});
    tbl.push_back('{159, 46, 'hFC});
    tbl.push_back('{144, 47, G});
    tbl.push_back('{783, 510, 'hE0});
    tbl.push_back('{784, 510, 'h00});
    tbl.push_back('{768, 495, 'hE0});
    tbl.push_back('{767, 510, 'h00});
    tbl.push_back('{783, 30, 'h00});
    tbl.push_back('{783, 31, G});
    tbl.push_back('{783, 511, 'h00});

    foreach (board[i]) board[i] = -1;
    m_clear = 1; m_pos = 0; hs_h = 3'b111; vs_h = 3'b111; exp_rgb = 0;
    p_act = 0; q_act = 0; q_code = 0; p_cell = 0; p_ox = 0; p_oy = 0; q_ox = 0; q_oy = 0;
    rst_n = 1'b0; hc = '0; vc = '0; hsync_in = 1'b1; vsync_in = 1'b1;
    wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; clr = 1'b0;

    tick();
    tick();
    check("reset_rgb", int'(rgb), 0);
    check("reset_hsync", int'(hsync), 1);
    check("reset_vsync", int'(vsync), 1);
    check("reset_busy", int'(busy), 1);

    // Initial clear sweep after reset release.
    rst_n = 1'b1;
    busy_run(n);
    check("busy_after_reset", n, 1200);
    scan_board("frame_after_reset");

    // Corner cells and dropped out-of-range writes.
    write_cell(0, 0, 2);
    write_cell(39, 29, 3);
    write_cell(40, 0, 1);
    write_cell(0, 30, 1);
    foreach (tbl[i]) begin
      probe(tbl[i].hc, tbl[i].vc, got);
      check($sformatf("vec%0d_h%0d_v%0d", i, tbl[i].hc, tbl[i].vc), got, tbl[i].rgb);
    end

    // hsync delay across one line; left blanking stays black over a non-empty cell.
    first_low = -1; low_cnt = 0; bad = 0; vc = 10'd31;
    for (int j = 0; j < 800; j++) begin
      hc = 10'(j);
      hsync_in = (j < 96) ? 1'b0 : 1'b1;
      tick();
      if (!hsync) begin
        low_cnt++;
        if (first_low < 0) first_low = j;
      end
      if (j >= 2 && j - 2 < 144 && rgb != 8'h00) bad++;
      if (j == 146) check("line_first_active", int'(rgb), 'hFC);
    end
    hc = '0; vc = '0; hsync_in = 1'b1;
    check("hsync_first_low", first_low, 2);
    check("hsync_low_count", low_cnt, 96);
    check("rgb_hblank", bad, 0);

    // Read-first: write lands on the same edge that reads the cell.
    hc = 10'(144 + 5 * 16 + 3); vc = 10'(31 + 5 * 16 + 3);
    tick();
    hc = '0; vc = '0;
    wr_en = 1'b1; wr_x = 6'd5; wr_y = 5'd5; wr_data = 2'd1;
    tick();
    wr_en = 1'b0;
    tick();
    check("read_first_old", int'(rgb), 'h00);
    probe(144 + 5 * 16 + 3, 31 + 5 * 16 + 3, got);
    check("read_first_new", got, 'h1C);

    // Clear with a dropped write at sweep address 600, then a restart mid-sweep.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 600; k++) tick();
    write_cell(0, 0, 3);
    check("busy_mid_clear", int'(busy), 1);
    probe(145, 32, got);
    check("clear_drop_write", got, 'h00);
    for (int k = 0; k < 100; k++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_run(n);
    check("busy_after_reclr", n, 1200);
    scan_board("frame_after_clear");

    // Reset in the middle of a sweep restarts it.
    write_cell(7, 3, 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    busy_run(n);
    check("busy_after_midreset", n, 1200);

    // Random traffic, half of it concentrated on a small corner to provoke read/write overlaps.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        hc = 10'($urandom_range(140, 211));
        vc = 10'($urandom_range(28, 95));
        wr_x = 6'($urandom_range(0, 3));
        wr_y = 5'($urandom_range(0, 3));
      end else begin
        hc = 10'($urandom_range(0, 799));
        vc = 10'($urandom_range(0, 524));
        wr_x = 6'($urandom_range(0, 45));
        wr_y = 5'($urandom_range(0, 33));
      end
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_data  = 2'($urandom_range(0, 3));
      clr      = ($urandom_range(0, 1999) == 0);
      tick();
    end
    wr_en = 1'b0; clr = 1'b0; hc = '0; vc = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
